axi_bram_log_reader: RTL and testbench

- Drains the 96-bit AXI log entries written into the dual-port log BRAM by the AXI logger, from index 0 upward.
- Decodes each entry into timestamp/address/length/ID fields and presents it on a valid/ready stream toward the host-side unload path.
- Stops at the first all-zero entry (cleared region) or after the last index, then pulses Done.
- Owns the BRAM read port only; never writes the BRAM.

---
 rtl/axi_bram_log_reader.sv | 142 ++++++++++++++
 tb/tb_axi_bram_log_reader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_bram_log_reader.sv
// Drains AXI log entries from the log BRAM read port, index 0 upward, into a
// 2-deep fall-through FIFO presented as a valid/ready stream of decoded fields.
module axi_bram_log_reader #(
  parameter int unsigned AXI_ID_BITW     = 8,
  parameter int unsigned TIMESTAMP_BITW  = 32,
  parameter int unsigned NUM_LOG_ENTRIES = 16384,
  parameter int unsigned AXI_ADDR_BITW   = 32,
  parameter int unsigned AXI_LEN_BITW    = 8
) (
  input  logic                              Clk_CI,
  input  logic                              Rst_RBI,
  input  logic                              Start_SI,
  input  logic                              Abort_SI,
  output logic                              Busy_SO,
  output logic                              Done_SO,
  output logic [$clog2(NUM_LOG_ENTRIES):0]  NumRead_DO,
  output logic                              BramEn_SO,
  output logic [$clog2(NUM_LOG_ENTRIES)-1:0] BramAddr_SO,
  input  logic [95:0]                       BramRd_DI,
  output logic                              Valid_SO,
  input  logic                              Ready_SI,
  output logic [TIMESTAMP_BITW-1:0]         Timestamp_DO,
  output logic [AXI_ADDR_BITW-1:0]          Addr_DO,
  output logic [AXI_LEN_BITW-1:0]           Len_DO,
  output logic [AXI_ID_BITW-1:0]            Id_DO
);

  localparam int unsigned CNT_BITW = $clog2(NUM_LOG_ENTRIES);
  localparam int unsigned NR_BITW  = CNT_BITW + 1;
  localparam logic [CNT_BITW-1:0] LAST_IDX = CNT_BITW'(NUM_LOG_ENTRIES - 1);

  typedef struct packed {
    logic [AXI_ID_BITW-1:0]    id;
    logic [AXI_LEN_BITW-1:0]   len;
    logic [AXI_ADDR_BITW-1:0]  addr;
    logic [TIMESTAMP_BITW-1:0] ts;
  } entry_t;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_e;

  state_e              state_q, state_d;
  logic [CNT_BITW-1:0] idx_q;
  logic                all_issued_q;
  logic                in_flight_q;
  logic [1:0]          occ_q;
  logic                wr_ptr_q, rd_ptr_q;
  entry_t              fifo_q [2];
  logic [NR_BITW-1:0]  num_read_q;

  logic   pop_c, push_c, issue_c, start_c, abort_c, ret_c, rd_zero_c;
  entry_t rd_entry_c;

  // Field extraction from the raw BRAM word; upper unused bits are dropped.
  always_comb begin
    rd_entry_c      = '0;
    rd_entry_c.ts   = BramRd_DI[TIMESTAMP_BITW-1:0];
    rd_entry_c.addr = BramRd_DI[63:32];
    rd_entry_c.len  = BramRd_DI[71:64];
    rd_entry_c.id   = BramRd_DI[72 +: AXI_ID_BITW];
  end

  // Handshake, return and issue qualifiers.
  always_comb begin
    pop_c     = (occ_q != 2'd0) && Ready_SI;
    rd_zero_c = (BramRd_DI == '0);
    abort_c   = Abort_SI && (state_q != IDLE);
    start_c   = (state_q == IDLE) && Start_SI && !Abort_SI;
    ret_c     = in_flight_q && (state_q == FETCH);
    push_c    = ret_c && !rd_zero_c && !Abort_SI;
    issue_c   = (state_q == FETCH) && !all_issued_q && !Abort_SI &&
                ((3'(occ_q) + 3'(in_flight_q)) < (3'd2 + 3'(pop_c)));
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_c) state_d = FETCH;
      FETCH:   if (ret_c && (rd_zero_c || all_issued_q)) state_d = DRAIN;
      DRAIN:   if (occ_q == 2'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_c) state_d = IDLE;
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Read index, in-flight tracking, handshake counter and FIFO storage.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      idx_q        <= '0;
      all_issued_q <= 1'b0;
      in_flight_q  <= 1'b0;
      num_read_q   <= '0;
      occ_q        <= 2'd0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
    end else begin
      in_flight_q <= issue_c;
      if (issue_c) begin
        if (idx_q == LAST_IDX) all_issued_q <= 1'b1;
        else                   idx_q        <= idx_q + CNT_BITW'(1);
      end
      if (start_c) begin
        idx_q        <= '0;
        all_issued_q <= 1'b0;
        num_read_q   <= '0;
      end else if (pop_c) begin
        num_read_q <= num_read_q + NR_BITW'(1);
      end
      if (start_c || abort_c) begin
        occ_q    <= 2'd0;
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
      end else begin
        if (push_c) begin
          fifo_q[wr_ptr_q] <= rd_entry_c;
          wr_ptr_q         <= ~wr_ptr_q;
        end
        if (pop_c) rd_ptr_q <= ~rd_ptr_q;
        occ_q <= occ_q + 2'(push_c) - 2'(pop_c);
      end
    end
  end

  assign Busy_SO      = (state_q != IDLE);
  assign Done_SO      = (state_q == DONE);
  assign NumRead_DO   = num_read_q;
  assign BramEn_SO    = issue_c;
  assign BramAddr_SO  = idx_q;
  assign Valid_SO     = (occ_q != 2'd0);
  assign Timestamp_DO = fifo_q[rd_ptr_q].ts;
  assign Addr_DO      = fifo_q[rd_ptr_q].addr;
  assign Len_DO       = fifo_q[rd_ptr_q].len;
  assign Id_DO        = fifo_q[rd_ptr_q].id;

endmodule

// File: tb/tb_axi_bram_log_reader.sv
// Scenario-table bench for axi_bram_log_reader with a BRAM model and an
// in-order scoreboard of expected decoded entries.
module tb_axi_bram_log_reader;

  localparam int unsigned N        = 1024;
  localparam int unsigned CNT_BITW = 10;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start, abort, ready;
  logic                busy, done, valid, bram_en;
  logic [CNT_BITW:0]   num_read;
  logic [CNT_BITW-1:0] bram_addr;
  logic [95:0]         bram_rd;
  logic [31:0]         ts, addr;
  logic [7:0]          len, id;

  always #5 clk = ~clk;

  axi_bram_log_reader #(
    .AXI_ID_BITW(8), .TIMESTAMP_BITW(32), .NUM_LOG_ENTRIES(N),
    .AXI_ADDR_BITW(32), .AXI_LEN_BITW(8)
  ) dut (
    .Clk_CI(clk), .Rst_RBI(rst_n), .Start_SI(start), .Abort_SI(abort),
    .Busy_SO(busy), .Done_SO(done), .NumRead_DO(num_read),
    .BramEn_SO(bram_en), .BramAddr_SO(bram_addr), .BramRd_DI(bram_rd),
    .Valid_SO(valid), .Ready_SI(ready), .Timestamp_DO(ts), .Addr_DO(addr),
    .Len_DO(len), .Id_DO(id)
  );

  logic [95:0] bram [N];
  always @(posedge clk) if (bram_en) bram_rd <= bram[bram_addr];

  typedef struct packed {
    logic [7:0]  id;
    logic [7:0]  len;
    logic [31:0] addr;
    logic [31:0] ts;
  } beat_t;

  typedef struct {
    int    n_nonzero;
    int    ready_mode;
    string name;
  } scen_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic beat_t mk_beat(input int k);
    beat_t b;
    b.ts   = 32'(k + 1);
    b.addr = 32'h1000 + 32'(4 * (k + 1));
    b.len  = 8'(k + 1);
    b.id   = 8'(8'hA0 + k + 1);
    return b;
  endfunction

  // Junk in bits 95:80 must be ignored by the decoder.
  function automatic logic [95:0] mk_entry(input int k);
    beat_t b;
    b = mk_beat(k);
    return {16'(k * 7 + 3), b.id, b.len, b.addr, b.ts};
  endfunction

  task automatic preload(input int n);
    exp_q.delete();
    for (int i = 0; i < int'(N); i++) bram[i] = (i < n) ? mk_entry(i) : 96'h0;
    for (int i = 0; i < n; i++) exp_q.push_back(mk_beat(i));
  endtask

  // Monitor state, sampled on the falling edge.
  int    cyc = 0;
  bit    active = 1'b0;
  int    start_cyc, first_valid_rel, first_en_rel, first_en_addr, max_addr;
  int    beats, first_beat_rel, last_beat_rel, done_cnt, done_rel;
  bit    prev_stall;
  beat_t held;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic mon_clear();
    first_valid_rel = -1; first_en_rel = -1; first_en_addr = -1; max_addr = -1;
    beats = 0; first_beat_rel = -1; last_beat_rel = -1; done_cnt = 0; done_rel = -1;
    prev_stall = 1'b0; held = '0;
  endtask

  always @(negedge clk) begin
    int    rel;
    beat_t cur;
    beat_t e;
    if (active) begin
      rel = cyc - start_cyc;
      cur = {id, len, addr, ts};
      if (done) begin done_cnt++; done_rel = rel; end
      if (bram_en) begin
        if (first_en_rel < 0) begin first_en_rel = rel; first_en_addr = int'(bram_addr); end
        if (int'(bram_addr) > max_addr) max_addr = int'(bram_addr);
      end
      if (prev_stall) check("stall_hold", {15'b0, valid, cur}, {15'b0, 1'b1, held});
      if (valid && first_valid_rel < 0) first_valid_rel = rel;
      if (valid && ready) begin
        beats++;
        if (first_beat_rel < 0) first_beat_rel = rel;
        last_beat_rel = rel;
        if (exp_q.size() == 0) check("extra_beat", {16'b0, cur}, 96'h0);
        else begin
          e = exp_q.pop_front();
          check("beat_fields", {16'b0, cur}, {16'b0, e});
        end
      end
      prev_stall = valid && !ready;
      held = cur;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic ready_val(input int mode, input int rel);
    case (mode)
      0:       return 1'b1;
      1:       return (rel % 3) == 0;
      default: return 1'($urandom_range(1, 0));
    endcase
  endfunction

  task automatic run_scen(input int n, input int mode, input string nm);
    preload(n);
    mon_clear();
    start = 1'b1; start_cyc = cyc; active = 1'b1; ready = ready_val(mode, 0);
    for (int r = 1; r < 4000; r++) begin
      tick();
      start = 1'b0;
      ready = ready_val(mode, r);
      if (done_cnt > 0 && !busy) break;
    end
    repeat (3) tick();
    active = 1'b0;
    check({nm, "_done_cnt"}, 96'(done_cnt), 96'(1));
    check({nm, "_busy"}, 96'(busy), 96'(0));
    check({nm, "_num_read"}, 96'(num_read), 96'(n));
    check({nm, "_beats"}, 96'(beats), 96'(n));
    check({nm, "_sb_left"}, 96'(exp_q.size()), 96'(0));
    check({nm, "_first_en"}, 96'(first_en_rel), 96'(1));
    check({nm, "_first_addr"}, 96'(first_en_addr), 96'(0));
    if (n > 0) check({nm, "_first_valid"}, 96'(first_valid_rel), 96'(3));
    if (mode == 0 && n > 0) check({nm, "_back_to_back"}, 96'(last_beat_rel - first_beat_rel), 96'(n - 1));
    if (n == 0) begin
      check({nm, "_done_rel"}, 96'(done_rel), 96'(4));
      check({nm, "_no_valid"}, 96'(first_valid_rel), 96'(-1));
    end
    if (n == int'(N)) check({nm, "_max_addr"}, 96'(max_addr), 96'(N - 1));
    exp_q.delete();
  endtask

  scen_t scen [5];
  bit    saw_done;

  initial begin
    scen[0] = '{5,    0, "five_ready"};
    scen[1] = '{5,    1, "five_toggle"};
    scen[2] = '{1024, 0, "full_depth"};
    scen[3] = '{0,    0, "zero_first"};
    scen[4] = '{37,   2, "random_ready"};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b0;
    for (int i = 0; i < int'(N); i++) bram[i] = 96'h0;
    repeat (3) tick();
    check("reset_outputs", {busy, done, valid, bram_en, bram_addr, num_read, ts, addr, len, id},
          96'h0);
    rst_n = 1'b1;
    tick();

    foreach (scen[i]) run_scen(scen[i].n_nonzero, scen[i].ready_mode, scen[i].name);

    // Abort with a full FIFO after three accepted beats.
    preload(5);
    mon_clear();
    start = 1'b1; start_cyc = cyc; active = 1'b1; ready = 1'b1;
    for (int r = 1; r <= 10; r++) begin
      tick();
      start = 1'b0;
      ready = (r <= 5);
    end
    check("abort_pre_valid", 96'(valid), 96'(1));
    abort = 1'b1; active = 1'b0;
    tick();
    abort = 1'b0;
    check("abort_outputs", {93'b0, valid, busy, bram_en}, 96'h0);
    check("abort_num_read", 96'(num_read), 96'(3));
    check("abort_beats", 96'(beats), 96'(3));
    saw_done = 1'b0;
    for (int r = 0; r < 5; r++) begin
      if (done) saw_done = 1'b1;
      tick();
    end
    check("abort_no_done", 96'(saw_done), 96'(0));
    check("abort_num_read_hold", 96'(num_read), 96'(3));
    exp_q.delete();

    // Start together with Abort in IDLE stays idle.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", {94'b0, busy, bram_en}, 96'h0);
    tick();

    // Asynchronous reset mid-drain, then a clean restart from index 0.
    preload(20);
    mon_clear();
    start = 1'b1; start_cyc = cyc; active = 1'b1; ready = 1'b1;
    for (int r = 1; r <= 7; r++) begin
      tick();
      start = 1'b0;
    end
    check("pre_reset_busy", 96'(busy), 96'(1));
    active = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {busy, done, valid, bram_en, bram_addr, num_read, ts, addr, len, id}, 96'h0);
    tick();
    rst_n = 1'b1;
    tick();
    run_scen(20, 0, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
